// File: rtl/slc3_mem_responder.sv
// SLC-3 on-chip memory responder.
// Answers level-held Mem_OE/Mem_WE strobes from the control FSM.
module slc3_mem_responder #(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 1,
    parameter int WRITE_LAT = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       Data_from_CPU,
    input  logic              Init_We,
    input  logic [ADDR_W-1:0] Init_Addr,
    input  logic [15:0]       Init_Data,
    output logic [15:0]       Data_to_CPU,
    output logic              Data_Valid,
    output logic              Wr_Done,
    output logic              Proto_Err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [2:0] RD_LAT = 3'(READ_LAT);
    localparam logic [2:0] WR_LAT = 3'(WRITE_LAT);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        WR_HOLD
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [1:0]        cnt;
    logic [1:0]        cnt_d;
    logic [1:0]        cnt_sat;
    logic [2:0]        cnt_nx;
    logic [15:0]       dout_d;
    logic              dv_d;
    logic              wd_d;
    logic              err_d;
    logic              conflict;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       ram [DEPTH];

    // Upper address bits alias; only the low ADDR_W bits select a word.
    assign addr = ADDR[ADDR_W-1:0];

    generate
        if (ADDR_W < 16) begin : g_alias
            logic unused_addr;
            assign unused_addr = ^ADDR[15:ADDR_W];
        end
    endgenerate

    assign cnt_nx   = {1'b0, cnt} + 3'd1;
    assign cnt_sat  = (cnt == 2'd3) ? 2'd3 : cnt_nx[1:0];
    assign conflict = Mem_OE & Mem_WE;

    // Next-state, output and RAM-write decisions for the strobe protocol.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        dout_d    = Data_to_CPU;
        dv_d      = Data_Valid;
        wd_d      = 1'b0;
        err_d     = Proto_Err;
        ram_we    = 1'b0;
        ram_waddr = addr;
        ram_wdata = Data_from_CPU;

        // Preload is only honoured on a quiet bus in IDLE.
        if (Init_We && (state != IDLE || Mem_OE || Mem_WE))
            err_d = 1'b1;

        if (conflict) begin
            err_d   = 1'b1;
            dv_d    = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Mem_OE) begin
                        dout_d  = ram[addr];
                        cnt_d   = 2'd1;
                        dv_d    = (RD_LAT == 3'd1);
                        state_d = READ;
                    end else if (Mem_WE) begin
                        cnt_d = 2'd1;
                        if (WR_LAT == 3'd1) begin
                            ram_we  = 1'b1;
                            wd_d    = 1'b1;
                            state_d = WR_HOLD;
                        end else begin
                            state_d = WRITE;
                        end
                    end else if (Init_We) begin
                        ram_we    = 1'b1;
                        ram_waddr = Init_Addr;
                        ram_wdata = Init_Data;
                        dv_d      = 1'b0;
                    end else begin
                        dv_d = 1'b0;
                    end
                end
                READ: begin
                    if (Mem_OE) begin
                        dout_d = ram[addr];
                        cnt_d  = cnt_sat;
                        dv_d   = (cnt_nx >= RD_LAT);
                    end else begin
                        dv_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
                WRITE: begin
                    if (Mem_WE) begin
                        cnt_d = cnt_sat;
                        if (cnt_nx == WR_LAT) begin
                            ram_we  = 1'b1;
                            wd_d    = 1'b1;
                            state_d = WR_HOLD;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                WR_HOLD: begin
                    if (!Mem_WE)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; Reset leaves the RAM alone.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            Data_to_CPU <= 16'h0000;
            Data_Valid  <= 1'b0;
            Wr_Done     <= 1'b0;
            Proto_Err   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            Data_to_CPU <= dout_d;
            Data_Valid  <= dv_d;
            Wr_Done     <= wd_d;
            Proto_Err   <= err_d;
        end
    end

    // Word RAM write port; a pending commit is dropped under Reset.
    always_ff @(posedge Clk) begin
        if (ram_we && !Reset)
            ram[ram_waddr] <= ram_wdata;
    end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: vector table, directed
// corner sequences and a randomized run against a bus-level model.
module tb_slc3_mem_responder;
    localparam int AW = 10;
    localparam int RL = 1;
    localparam int WL = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_OE = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] ADDR = '0;
    logic [15:0] Data_from_CPU = '0;
    logic        Init_We = 1'b0;
    logic [9:0]  Init_Addr = '0;
    logic [15:0] Init_Data = '0;
    logic [15:0] Data_to_CPU;
    logic        Data_Valid;
    logic        Wr_Done;
    logic        Proto_Err;

    slc3_mem_responder #(
        .ADDR_W   (AW),
        .READ_LAT (RL),
        .WRITE_LAT(WL)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Mem_OE       (Mem_OE),
        .Mem_WE       (Mem_WE),
        .ADDR         (ADDR),
        .Data_from_CPU(Data_from_CPU),
        .Init_We      (Init_We),
        .Init_Addr    (Init_Addr),
        .Init_Data    (Init_Data),
        .Data_to_CPU  (Data_to_CPU),
        .Data_Valid   (Data_Valid),
        .Wr_Done      (Wr_Done),
        .Proto_Err    (Proto_Err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Bus-level model: run lengths of the current access.
    logic [15:0] mem [1024];
    int          rd_run = 0;
    int          wr_run = 0;
    bit          committed = 0;
    logic [15:0] m_dout = '0;
    logic        m_dv = 0;
    logic        m_wd = 0;
    logic        m_err = 0;

    typedef struct {
        logic        rst;
        logic        oe;
        logic        we;
        logic        iw;
        logic [15:0] a;
        logic [15:0] d;
        logic [9:0]  ia;
        logic [15:0] idat;
        logic [15:0] e_dout;
        logic        e_dv;
        logic        e_wd;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 37) ^ 16'h3C3C;
    endfunction

    function automatic vec_t mk(
        input logic rst, input logic oe, input logic we, input logic iw,
        input logic [15:0] a, input logic [15:0] d,
        input logic [9:0] ia, input logic [15:0] idat,
        input logic [15:0] e_dout, input logic e_dv,
        input logic e_wd, input logic e_err);
        vec_t v;
        v.rst = rst; v.oe = oe; v.we = we; v.iw = iw;
        v.a = a; v.d = d; v.ia = ia; v.idat = idat;
        v.e_dout = e_dout; v.e_dv = e_dv;
        v.e_wd = e_wd; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int a;
        bit idle;
        a = int'(ADDR[9:0]);
        if (Reset) begin
            rd_run = 0; wr_run = 0; committed = 0;
            m_dout = '0; m_dv = 0; m_wd = 0; m_err = 0;
            return;
        end
        m_wd = 0;
        idle = (rd_run == 0 && wr_run == 0);
        if (Init_We && (!idle || Mem_OE || Mem_WE))
            m_err = 1;
        if (Mem_OE && Mem_WE) begin
            m_err = 1; m_dv = 0;
            rd_run = 0; wr_run = 0; committed = 0;
        end else if (rd_run > 0) begin
            if (Mem_OE) begin
                rd_run++;
                m_dout = mem[a];
                m_dv = (rd_run >= RL);
            end else begin
                rd_run = 0; m_dv = 0;
            end
        end else if (wr_run > 0) begin
            if (!Mem_WE) begin
                if (!committed) m_err = 1;
                wr_run = 0; committed = 0;
            end else begin
                wr_run++;
                if (!committed && wr_run == WL) begin
                    mem[a] = Data_from_CPU;
                    committed = 1; m_wd = 1;
                end
            end
        end else if (Mem_OE) begin
            rd_run = 1;
            m_dout = mem[a];
            m_dv = (RL <= 1);
        end else if (Mem_WE) begin
            wr_run = 1;
            if (WL == 1) begin
                mem[a] = Data_from_CPU;
                committed = 1; m_wd = 1;
            end
        end else begin
            m_dv = 0;
            if (Init_We) mem[int'(Init_Addr)] = Init_Data;
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        chk({tag, " dout"}, Data_to_CPU, m_dout);
        chk({tag, " valid"}, 16'(Data_Valid), 16'(m_dv));
        chk({tag, " wrdone"}, 16'(Wr_Done), 16'(m_wd));
        chk({tag, " perr"}, 16'(Proto_Err), 16'(m_err));
    endtask

    task automatic drive(input logic rst, input logic oe, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        Reset = rst; Mem_OE = oe; Mem_WE = we;
        ADDR = a; Data_from_CPU = d; Init_We = 1'b0;
    endtask

    task automatic init(input logic [9:0] ia, input logic [15:0] idat);
        drive(0, 0, 0, 16'h0, 16'h0);
        Init_We = 1'b1; Init_Addr = ia; Init_Data = idat;
        cycle("init");
        Init_We = 1'b0;
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        @(negedge Clk);
        drive(1, 0, 0, 16'h0, 16'h0);
        cycle("reset");
        chk("reset dout", Data_to_CPU, 16'h0000);
        chk("reset perr", 16'(Proto_Err), 16'h0);

        for (int i = 0; i < 1024; i++) init(10'(i), pat(i));

        // rst oe we iw  a  d  ia  idat  dout dv wd err
        tbl.push_back(mk(1,0,0,0,16'h0,16'h0,10'h0,16'h0,16'h0000,0,0,0));
        tbl.push_back(mk(0,0,0,1,16'h0,16'h0,10'h5,16'h1234,16'h0000,0,0,0));
        tbl.push_back(mk(0,0,0,1,16'h0,16'h0,10'h11,16'h0,16'h0000,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,1,0,0,16'h5,16'h0,10'h0,16'h0,16'h1234,1,0,0));
        tbl.push_back(mk(0,0,0,0,16'h5,16'h0,10'h0,16'h0,16'h1234,0,0,0));
        tbl.push_back(mk(0,0,1,0,16'h10,16'hBEEF,10'h0,16'h0,16'h1234,0,0,0));
        tbl.push_back(mk(0,0,1,0,16'h10,16'hBEEF,10'h0,16'h0,16'h1234,0,0,0));
        tbl.push_back(mk(0,0,1,0,16'h10,16'hBEEF,10'h0,16'h0,16'h1234,0,1,0));
        tbl.push_back(mk(0,0,0,0,16'h10,16'h0,10'h0,16'h0,16'h1234,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,1,0,0,16'h10,16'h0,10'h0,16'h0,16'hBEEF,1,0,0));
        tbl.push_back(mk(0,0,0,0,16'h10,16'h0,10'h0,16'h0,16'hBEEF,0,0,0));
        tbl.push_back(mk(0,0,1,0,16'h11,16'hAAAA,10'h0,16'h0,16'hBEEF,0,0,0));
        tbl.push_back(mk(0,0,1,0,16'h11,16'hAAAA,10'h0,16'h0,16'hBEEF,0,0,0));
        tbl.push_back(mk(0,0,0,0,16'h11,16'h0,10'h0,16'h0,16'hBEEF,0,0,1));
        tbl.push_back(mk(0,1,0,0,16'h11,16'h0,10'h0,16'h0,16'h0000,1,0,1));
        tbl.push_back(mk(0,1,0,0,16'h11,16'h0,10'h0,16'h0,16'h0000,1,0,1));
        tbl.push_back(mk(0,0,0,0,16'h11,16'h0,10'h0,16'h0,16'h0000,0,0,1));

        foreach (tbl[i]) begin
            string n;
            n = $sformatf("v%0d", i);
            drive(tbl[i].rst, tbl[i].oe, tbl[i].we, tbl[i].a, tbl[i].d);
            Init_We = tbl[i].iw;
            Init_Addr = tbl[i].ia;
            Init_Data = tbl[i].idat;
            cycle(n);
            chk({n, " tbl dout"}, Data_to_CPU, tbl[i].e_dout);
            chk({n, " tbl valid"}, 16'(Data_Valid), 16'(tbl[i].e_dv));
            chk({n, " tbl wrdone"}, 16'(Wr_Done), 16'(tbl[i].e_wd));
            chk({n, " tbl perr"}, 16'(Proto_Err), 16'(tbl[i].e_err));
        end
        Init_We = 1'b0;

        // OE and WE together.
        drive(1, 0, 0, 16'h0, 16'h0); cycle("s4 rst");
        drive(0, 1, 1, 16'h5, 16'h7777); cycle("s4 both");
        chk("s4 perr", 16'(Proto_Err), 16'h1);
        chk("s4 valid", 16'(Data_Valid), 16'h0);
        drive(0, 0, 0, 16'h5, 16'h0); cycle("s4 idle");
        drive(0, 1, 0, 16'h5, 16'h0); cycle("s4 rd");
        chk("s4 ram5", Data_to_CPU, 16'h1234);
        drive(0, 0, 0, 16'h5, 16'h0); cycle("s4 idle2");

        // Reset during WE cycle 2.
        drive(1, 0, 0, 16'h0, 16'h0); cycle("s5 rst");
        drive(0, 0, 1, 16'h20, 16'h5555); cycle("s5 we1");
        drive(1, 0, 1, 16'h20, 16'h5555); cycle("s5 we2");
        chk("s5 dout", Data_to_CPU, 16'h0000);
        chk("s5 valid", 16'(Data_Valid), 16'h0);
        chk("s5 wrdone", 16'(Wr_Done), 16'h0);
        chk("s5 perr", 16'(Proto_Err), 16'h0);
        drive(0, 0, 0, 16'h0, 16'h0); cycle("s5 idle");
        drive(0, 1, 0, 16'h20, 16'h0); cycle("s5 rd20");
        chk("s5 ram20", Data_to_CPU, pat(32));
        drive(0, 0, 0, 16'h0, 16'h0); cycle("s5 idle2");
        drive(0, 1, 0, 16'h5, 16'h0); cycle("s5 rd5");
        chk("s5 ram5", Data_to_CPU, 16'h1234);
        drive(0, 0, 0, 16'h0, 16'h0); cycle("s5 idle3");

        // Fetch-like sequence with aliasing and a long WE.
        drive(1, 0, 0, 16'h0, 16'h0); cycle("s6 rst");
        init(10'h0, 16'h1111);
        init(10'h1, 16'h2222);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 16'h0400, 16'h0); cycle("s6 rd0");
            chk("s6 alias", Data_to_CPU, 16'h1111);
            chk("s6 v0", 16'(Data_Valid), 16'h1);
        end
        drive(0, 0, 0, 16'h0, 16'h0); cycle("s6 gap");
        chk("s6 gap valid", 16'(Data_Valid), 16'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 16'h0001, 16'h0); cycle("s6 rd1");
            chk("s6 rd1 data", Data_to_CPU, 16'h2222);
            chk("s6 v1", 16'(Data_Valid), 16'h1);
        end
        drive(0, 0, 0, 16'h0, 16'h0); cycle("s6 gap2");
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 16'h30, 16'hCAFE); cycle("s6 we");
            if (Wr_Done) pulses++;
            chk("s6 pulse pos", 16'(Wr_Done), 16'(k == 2));
        end
        chk("s6 pulses", 16'(pulses), 16'd1);
        drive(0, 0, 0, 16'h0, 16'h0); cycle("s6 gap3");
        drive(0, 1, 0, 16'h30, 16'h0); cycle("s6 rd30");
        chk("s6 ram30", Data_to_CPU, 16'hCAFE);
        chk("s6 perr", 16'(Proto_Err), 16'h0);
        drive(0, 0, 0, 16'h0, 16'h0); cycle("s6 end");

        // Randomized bursts against the model.
        for (int b = 0; b < 400; b++) begin
            int op;
            int len;
            logic [15:0] a;
            op = int'($urandom_range(0, 9));
            a = {6'($urandom), 10'($urandom_range(0, 15))};
            if (op <= 3) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 3) == 0)
                        a = {6'($urandom), 10'($urandom_range(0, 15))};
                    drive(0, 1, 0, a, 16'($urandom));
                    cycle("rnd rd");
                end
            end else if (op <= 6) begin
                len = int'($urandom_range(1, 5));
                for (int k = 0; k < len; k++) begin
                    drive(0, 0, 1, a, 16'($urandom));
                    cycle("rnd wr");
                end
            end else if (op == 7) begin
                drive(0, 1, 1, a, 16'($urandom));
                cycle("rnd both");
            end else if (op == 8) begin
                drive(0, ($urandom_range(0, 3) == 0), 1'b0, a, 16'h0);
                Init_We = 1'b1;
                Init_Addr = 10'($urandom_range(0, 15));
                Init_Data = 16'($urandom);
                cycle("rnd init");
                Init_We = 1'b0;
            end else begin
                drive(($urandom_range(0, 3) == 0), 0, 0, a, 16'h0);
                cycle("rnd idle");
            end
            len = int'($urandom_range(0, 2));
            for (int k = 0; k < len; k++) begin
                drive(0, 0, 0, a, 16'h0);
                cycle("rnd gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
